wshb_pixel_reader: RTL

Framebuffer read master for the video controller. Fetches pixels sequentially from memory over the Wishbone master port and pushes them into the pixel FIFO write port. Generates the one-cycle `fill_set` pulse that drives the `set` input of the shared set/reset flag; that flag tells the display FSM the FIFO has been primed and scan-out may start.

---
 rtl/wshb_pixel_reader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/wshb_pixel_reader.sv
// Wishbone framebuffer read master feeding the pixel FIFO, with one-shot FIFO-primed pulse.
// Optional PIXREAD_FRAME_CNT_EN adds a 16-bit frame counter output.
module wshb_pixel_reader #(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [3:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic [1:0]  wb_bte,
  input  logic        wb_ack,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] fifo_wdata,
  output logic        fifo_write,
  input  logic        fifo_wfull,
  input  logic        fifo_walmost_full,
  input  logic        frame_restart,
  output logic        fill_set
`ifdef PIXREAD_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int NPIX = HDISP * VDISP;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FULLWAIT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      fifo_wdata_q, fifo_wdata_d;
  logic             fifo_write_q, fifo_write_d;
  logic             armed_q, armed_d;
  logic             fill_set_q, fill_set_d;
  logic             accept;
  logic             wrap;
  logic [31:0]      idx_ext;

  // An ack colliding with frame_restart is dropped entirely.
  assign accept  = (state_q == S_READ) && wb_ack && !frame_restart;
  assign wrap    = accept && (idx_q == LAST_IDX);
  assign idx_ext = 32'(idx_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Backoff is decided at the ack so a presented request is never withdrawn.
  always_comb begin
    state_d = state_q;
    if (frame_restart) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     state_d = S_READ;
        S_READ:     if (wb_ack && fifo_walmost_full) state_d = S_FULLWAIT;
        S_FULLWAIT: if (!fifo_walmost_full) state_d = S_READ;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wb_cyc = (state_q == S_READ);
    wb_stb = (state_q == S_READ);
    wb_we  = 1'b0;
    wb_sel = 4'hF;
    wb_cti = 3'b000;
    wb_bte = 2'b00;
    wb_adr = BASE_ADDR + (idx_ext << 2);
  end

  always_comb begin
    idx_d        = idx_q;
    fifo_wdata_d = fifo_wdata_q;
    fifo_write_d = 1'b0;
    armed_d      = armed_q;
    fill_set_d   = 1'b0;
    if (frame_restart) begin
      idx_d   = '0;
      armed_d = 1'b1;
    end else begin
      if (accept) begin
        idx_d        = wrap ? '0 : idx_q + 1'b1;
        fifo_wdata_d = wb_dat_i;
        fifo_write_d = 1'b1;
      end
      if (armed_q && fifo_wfull) begin
        fill_set_d = 1'b1;
        armed_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q        <= '0;
      fifo_wdata_q <= '0;
      fifo_write_q <= 1'b0;
      armed_q      <= 1'b1;
      fill_set_q   <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      fifo_wdata_q <= fifo_wdata_d;
      fifo_write_q <= fifo_write_d;
      armed_q      <= armed_d;
      fill_set_q   <= fill_set_d;
    end
  end

  assign fifo_wdata = fifo_wdata_q;
  assign fifo_write = fifo_write_q;
  assign fill_set   = fill_set_q;

`ifdef PIXREAD_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_restart) begin
      frame_cnt_d = '0;
    end else if (wrap) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
